// File: rtl/fetch_unit.sv
// BEAN-2 fetch stage: req/ack instruction-memory port feeding a small prefetch FIFO toward decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect sets a sticky error and halts fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_F,
    input  logic        flush_F,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid_D,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic        misalign_err
);
    // state | meaning
    // IDLE  | no request outstanding; issue one when the FIFO has room
    // WAIT  | request on the port, waiting for imem_ack
    // DROP  | flushed while waiting; swallow the returning ack
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       mem_pc_q    [FIFO_DEPTH];
    logic [31:0]       mem_instr_q [FIFO_DEPTH];
    logic              push, pop, issue, halt;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (flush_F && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign halt         = misalign_q;
    assign misalign_err = misalign_q;
`else
    assign halt         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (!flush_F && !halt && (count_q < DEPTH_C)) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ack)     state_d = S_IDLE;
                else if (flush_F) state_d = S_DROP;
            end
            S_DROP: if (imem_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Only one request is ever outstanding, so in-flight occupancy is just "in WAIT".
    always_comb begin
        issue      = (state_q == S_IDLE) && (state_d == S_WAIT);
        push       = (state_q == S_WAIT) && imem_ack && !flush_F;
        pop        = (count_q != '0) && !stall_F && !flush_F;
        req_d      = (state_d == S_WAIT);
        addr_d     = issue ? fetch_pc_q : addr_q;
        fetch_pc_d = fetch_pc_q;
        if (flush_F) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            if (flush_F) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push && !pop)      count_q <= count_q + CNT_W'(1);
                else if (pop && !push) count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign valid_D   = (count_q != '0);
    assign instr_D   = valid_D ? mem_instr_q[rd_ptr_q] : NOP;
    assign pc_D      = valid_D ? mem_pc_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized memory latency, stalls and flushes against a
// transaction-level queue model of the decode-visible instruction stream.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset, stall_F, flush_F, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, valid_D, misalign_err;
    logic [31:0] imem_addr, instr_D, pc_D;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall_F(stall_F), .flush_F(flush_F),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .valid_D(valid_D),
        .instr_D(instr_D), .pc_D(pc_D), .misalign_err(misalign_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // reference model: words decode should see, next fetch address, drop/halt status
    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_drop, m_halt, m_err;
    // memory responder
    bit          out_pend;
    int          out_age, out_lat, lat_fixed;
    logic [31:0] out_addr;
    int          gap, new_reqs;
    logic [31:0] pop_log[$];

    task automatic model_reset();
        m_q.delete();
        pop_log.delete();
        m_pc     = RST_PC;
        m_drop   = 0;
        m_halt   = 0;
        m_err    = 0;
        out_pend = 0;
        gap      = 0;
        new_reqs = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1; stall_F = 0; flush_F = 0; imem_ack = 0;
        redirect_pc = 0; imem_rdata = 0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    // One clock: score current outputs, drive this cycle's inputs, advance the model past the edge.
    task automatic step(input bit stall, input bit flush, input logic [31:0] redir,
                        input bit flush_on_ack, input bit stale_ack);
        bit   ack, fl, new_req;
        ent_t e;
        total++;
        if (valid_D !== (m_q.size() != 0)) begin
            bad++; $display("FAIL valid_D: got %0b want %0b", valid_D, m_q.size() != 0);
        end
        total++;
        if (m_q.size() != 0) begin
            if (pc_D !== m_q[0].pc || instr_D !== m_q[0].instr) begin
                bad++; $display("FAIL head: got pc=%h instr=%h want pc=%h instr=%h",
                                pc_D, instr_D, m_q[0].pc, m_q[0].instr);
            end
        end else if (pc_D !== 32'h0 || instr_D !== NOP) begin
            bad++; $display("FAIL empty_head: got pc=%h instr=%h want pc=0 instr=%h", pc_D, instr_D, NOP);
        end
        total++;
        if (misalign_err !== m_err) begin
            bad++; $display("FAIL misalign_err: got %0b want %0b", misalign_err, m_err);
        end
        total++;
        if (imem_req === 1'b1 && (m_drop || m_halt)) begin
            bad++; $display("FAIL req_blocked: got req=1 want 0 (drop=%0b halt=%0b)", m_drop, m_halt);
        end
        new_req = (imem_req === 1'b1) && !out_pend;
        if (new_req) begin
            total++;
            if (imem_addr !== m_pc || m_q.size() >= DEPTH) begin
                bad++; $display("FAIL req_addr: got addr=%h occ=%0d want addr=%h occ<%0d",
                                imem_addr, m_q.size(), m_pc, DEPTH);
            end
            out_pend = 1; out_age = 0; out_addr = imem_addr;
            out_lat  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
            new_reqs++;
        end else if (out_pend && !m_drop) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== out_addr) begin
                bad++; $display("FAIL req_hold: got req=%0b addr=%h want req=1 addr=%h",
                                imem_req, imem_addr, out_addr);
            end
        end
        if (!out_pend && imem_req !== 1'b1 && m_q.size() < DEPTH && !m_halt) gap++;
        else gap = 0;
        total++;
        if (gap > 1) begin
            bad++; $display("FAIL req_gap: got %0d idle cycles with room want <=1", gap);
        end

        ack = out_pend && (out_age >= out_lat);
        if (stale_ack && !out_pend) ack = 1;
        fl = flush || (flush_on_ack && ack && out_pend);
        stall_F     = stall;
        flush_F     = fl;
        redirect_pc = redir;
        imem_ack    = ack;
        imem_rdata  = (ack && out_pend) ? (out_addr ^ 32'h0000_AAAA) : $urandom;

        if (fl) begin
            m_q.delete();
            m_pc = redir & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redir[1:0] != 2'b00) begin m_err = 1; m_halt = 1; end
`endif
            if (out_pend && !ack) m_drop = 1;
            gap = 0;
        end else begin
            if (m_q.size() != 0 && !stall) begin
                pop_log.push_back(m_q[0].pc);
                void'(m_q.pop_front());
            end
            if (ack && out_pend && !m_drop) begin
                e.pc = m_pc; e.instr = out_addr ^ 32'h0000_AAAA;
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        if (ack && out_pend) begin
            out_pend = 0; m_drop = 0;
        end else if (out_pend) begin
            out_age++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 30 && imem_req !== 1'b1; i++) step(0, 0, 32'h0, 0, 0);
        total++;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL wait_req: got req=0 want 1 (timeout)"); end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && valid_D !== 1'b1; i++) step(0, 0, 32'h0, 0, 0);
        total++;
        if (valid_D !== 1'b1) begin bad++; $display("FAIL wait_valid: got valid=0 want 1 (timeout)"); end
    endtask

    task automatic test_reset();
        lat_fixed = 1;
        do_reset(3);
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || valid_D !== 1'b0 || instr_D !== NOP ||
            pc_D !== 32'h0 || misalign_err !== 1'b0) begin
            bad++; $display("FAIL reset_state: got req=%0b addr=%h valid=%0b instr=%h pc=%h err=%0b",
                            imem_req, imem_addr, valid_D, instr_D, pc_D, misalign_err);
        end
        step(0, 0, 32'h0, 0, 1);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            bad++; $display("FAIL first_req: got req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        lat_fixed = 1;
        do_reset(2);
        wait_valid();
        total++;
        if (pc_D !== 32'h100 || instr_D !== 32'h0000_ABAA) begin
            bad++; $display("FAIL first_head: got pc=%h instr=%h want pc=100 instr=0000abaa", pc_D, instr_D);
        end
        run(24);
        total++;
        if (pop_log.size() < 6) begin
            bad++; $display("FAIL stream_rate: got %0d pops want >=6", pop_log.size());
        end
        for (int i = 0; i < pop_log.size(); i++) begin
            total++;
            if (pop_log[i] !== RST_PC + 32'(4 * i)) begin
                bad++; $display("FAIL stream_order[%0d]: got %h want %h", i, pop_log[i], RST_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        lat_fixed = 1;
        do_reset(2);
        wait_valid();
        new_reqs = 0;
        repeat (6) step(1, 0, 32'h0, 0, 0);
        total++;
        if (new_reqs != 1 || imem_req !== 1'b0 || pc_D !== 32'h100 || instr_D !== 32'h0000_ABAA) begin
            bad++; $display("FAIL stall_hold: got reqs=%0d req=%0b pc=%h instr=%h want reqs=1 req=0 pc=100 instr=0000abaa",
                            new_reqs, imem_req, pc_D, instr_D);
        end
        pop_log.delete();
        run(12);
        total++;
        if (pop_log.size() < 3 || pop_log[0] !== 32'h100 || pop_log[1] !== 32'h104 || pop_log[2] !== 32'h108) begin
            bad++; $display("FAIL stall_release: got %0d pops first=%h want 100,104,108",
                            pop_log.size(), (pop_log.size() != 0) ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_flush_wait();
        lat_fixed = 4;
        do_reset(2);
        wait_req();
        step(0, 0, 32'h0, 0, 0);
        step(0, 1, 32'h2000, 0, 0);
        total++;
        if (imem_req !== 1'b0 || valid_D !== 1'b0) begin
            bad++; $display("FAIL flush_drop: got req=%0b valid=%0b want req=0 valid=0", imem_req, valid_D);
        end
        wait_req();
        total++;
        if (imem_addr !== 32'h2000) begin
            bad++; $display("FAIL flush_redirect_addr: got %h want 00002000", imem_addr);
        end
        wait_valid();
        total++;
        if (pc_D !== 32'h2000) begin bad++; $display("FAIL flush_first_pc: got %h want 00002000", pc_D); end
    endtask

    task automatic test_flush_ack();
        lat_fixed = 1;
        do_reset(2);
        wait_req();
        step(0, 0, 32'h40, 1, 0);
        step(0, 0, 32'h40, 1, 0);
        total++;
        if (valid_D !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL flush_ack_drop: got valid=%0b req=%0b want 0 0", valid_D, imem_req);
        end
        wait_req();
        total++;
        if (imem_addr !== 32'h40) begin bad++; $display("FAIL flush_ack_addr: got %h want 00000040", imem_addr); end
        wait_valid();
        total++;
        if (pc_D !== 32'h40) begin bad++; $display("FAIL flush_ack_pc: got %h want 00000040", pc_D); end
    endtask

    task automatic test_wrap();
        lat_fixed = 0;
        step(0, 1, 32'hFFFF_FFF8, 0, 0);
        pop_log.delete();
        run(40);
        total++;
        if (pop_log.size() < 3 || pop_log[0] !== 32'hFFFF_FFF8 || pop_log[1] !== 32'hFFFF_FFFC ||
            pop_log[2] !== 32'h0) begin
            bad++; $display("FAIL wrap: got %0d pops first=%h want fffffff8,fffffffc,00000000",
                            pop_log.size(), (pop_log.size() != 0) ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        lat_fixed = 3;
        do_reset(2);
        wait_req();
        step(0, 0, 32'h0, 0, 0);
        do_reset(2);
        step(0, 0, 32'h0, 0, 1);
        wait_valid();
        total++;
        if (pc_D !== RST_PC) begin bad++; $display("FAIL reset_mid_pc: got %h want %h", pc_D, RST_PC); end
    endtask

    task automatic test_misalign();
        lat_fixed = 2;
        do_reset(2);
        run(7);
        step(0, 1, 32'h102, 0, 0);
        new_reqs = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
        run(12);
        total++;
        if (misalign_err !== 1'b1 || valid_D !== 1'b0 || new_reqs != 0) begin
            bad++; $display("FAIL misalign_halt: got err=%0b valid=%0b reqs=%0d want 1 0 0",
                            misalign_err, valid_D, new_reqs);
        end
        do_reset(2);
        total++;
        if (misalign_err !== 1'b0) begin bad++; $display("FAIL misalign_reset: got %0b want 0", misalign_err); end
`else
        wait_valid();
        total++;
        if (pc_D !== 32'h100 || misalign_err !== 1'b0) begin
            bad++; $display("FAIL misalign_forced: got pc=%h err=%0b want pc=100 err=0", pc_D, misalign_err);
        end
`endif
    endtask

    task automatic test_random();
        lat_fixed = 0;
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 10) < 3, ($urandom % 25) == 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 ($urandom % 40) == 0, 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_wait();
        test_flush_ack();
        test_wrap();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
